// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and bus-level constants used by
// both the master and the register-file target.
package i2c_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam logic        I2C_ACK       = 1'b0;
  localparam logic        I2C_NACK      = 1'b1;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    REG       = 4'd3,
    REG_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    WAIT_STOP = 4'd9
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Oversampling front end for SCL/SDA: 2-flop synchronizers, a history flop,
// and registered single-cycle edge / START / STOP indications.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_prev;
  logic       sda_prev;
  logic       scl_sync;
  logic       sda_sync;

  assign scl_sync = scl_ff[1];
  assign sda_sync = sda_ff[1];

  // Synchronizers keep tracking through reset so no phantom edge appears on release.
  always_ff @(posedge clk) begin
    scl_ff   <= {scl_ff[0], scl_in};
    sda_ff   <= {sda_ff[0], sda_in};
    scl_prev <= scl_sync;
    sda_prev <= sda_sync;
  end

  // A condition needs SCL stable high across the SDA transition; a simultaneous
  // SCL change is treated as a plain clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_s     <= 1'b1;
    end else begin
      scl_rise  <= scl_sync & ~scl_prev;
      scl_fall  <= ~scl_sync & scl_prev;
      start_det <= scl_sync & scl_prev & sda_prev & ~sda_sync;
      stop_det  <= scl_sync & scl_prev & ~sda_prev & sda_sync;
      sda_s     <= sda_sync;
    end
  end

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with a byte register file: address match, register pointer,
// auto-incrementing burst writes and reads.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_bus_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_e state;
  logic [2:0] bit_cnt;
  logic [6:0] shift_q;
  logic [7:0] tx_shift;
  logic [7:0] ptr;
  logic       rw;
  logic       ack_phase;
  logic       got_ack;
  logic [7:0] regs [NUM_REGS];

  logic [7:0] rx_byte_c;
  logic       last_bit_c;
  logic       ptr_ok_c;
  logic [7:0] rd_byte_c;

  assign rx_byte_c  = {shift_q, sda_s};
  assign last_bit_c = (bit_cnt == 3'(BITS_PER_BYTE - 1));
  assign ptr_ok_c   = ({1'b0, ptr} < 9'(NUM_REGS));
  assign rd_byte_c  = ptr_ok_c ? regs[ptr[IDX_W-1:0]] : 8'hFF;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift_q   <= 7'd0;
      tx_shift  <= 8'd0;
      ptr       <= 8'd0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      got_ack   <= 1'b0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 8'd0;
      busy      <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (stop_det) begin
        state     <= IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        ack_phase <= 1'b0;
      end else if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          // Receive phases: shift MSB-first on SCL rise, act on the 8th bit.
          ADDR, REG, WDATA: begin
            if (scl_rise) begin
              shift_q <= rx_byte_c[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit_c) begin
                if (state == ADDR) begin
                  if (rx_byte_c[7:1] == SLAVE_ADDR) begin
                    rw    <= rx_byte_c[0];
                    state <= ADDR_ACK;
                  end else begin
                    state <= WAIT_STOP;
                  end
                end else if (state == REG) begin
                  ptr   <= rx_byte_c;
                  state <= REG_ACK;
                end else begin
                  if (ptr_ok_c) begin
                    regs[ptr[IDX_W-1:0]] <= rx_byte_c;
                    wr_strobe <= 1'b1;
                    wr_addr   <= ptr;
                    wr_data   <= rx_byte_c;
                  end
                  ptr   <= ptr + 8'd1;
                  state <= WDATA_ACK;
                end
              end
            end
          end
          // First fall drives the ACK, second fall ends the 9th slot.
          ADDR_ACK, REG_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= 3'd0;
                if (state == ADDR_ACK && rw) begin
                  state    <= RDATA;
                  sda_oe   <= ~rd_byte_c[7];
                  tx_shift <= {rd_byte_c[6:0], 1'b0};
                end else begin
                  sda_oe <= 1'b0;
                  state  <= (state == ADDR_ACK) ? REG : WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit_c) begin
                state   <= RDATA_ACK;
                got_ack <= 1'b0;
              end
            end else if (scl_fall) begin
              sda_oe   <= ~tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
          // Release SDA for the master's ACK; on ACK the next byte goes out at the following fall.
          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_s == I2C_ACK) begin
                got_ack <= 1'b1;
                ptr     <= ptr + 8'd1;
              end else begin
                state <= WAIT_STOP;
              end
            end else if (scl_fall) begin
              if (got_ack) begin
                got_ack  <= 1'b0;
                bit_cnt  <= 3'd0;
                state    <= RDATA;
                sda_oe   <= ~rd_byte_c[7];
                tx_shift <= {rd_byte_c[6:0], 1'b0};
              end else begin
                sda_oe <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bus-level master drives table-driven
// transactions, plus hand-written partial-byte and reset-during-ACK sequences.
module tb_i2c_slave_regs;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .NUM_REGS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         n_pass  = 0;
  int         n_total = 0;
  int         stb_cnt = 0;
  int         stb_err = 0;
  logic       stb_prev = 1'b0;
  logic [7:0] stb_addr = 8'h00;
  logic [7:0] stb_data = 8'h00;

  always @(negedge clk) begin
    if (wr_strobe) begin
      stb_cnt  <= stb_cnt + 1;
      stb_addr <= wr_addr;
      stb_data <= wr_data;
      if (stb_prev) stb_err <= stb_err + 1;
    end
    stb_prev <= wr_strobe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; clks(4);
    scl_m = 1'b1; clks(4);
    sda_m = 1'b0; clks(4);
    scl_m = 1'b0; clks(4);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clks(4);
    scl_m = 1'b1; clks(4);
    sda_m = 1'b1; clks(4);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    clks(4);
    scl_m = 1'b1; clks(8);
    scl_m = 1'b0; clks(4);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    sda_m = 1'b1; clks(4);
    scl_m = 1'b1; clks(4);
    @(negedge clk);
    ack = sda_in;
    clks(4);
    scl_m = 1'b0; clks(4);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      clks(4);
      scl_m = 1'b1; clks(4);
      @(negedge clk);
      b[i] = sda_in;
      clks(4);
      scl_m = 1'b0; clks(4);
    end
    sda_m = ack;  clks(4);
    scl_m = 1'b1; clks(8);
    scl_m = 1'b0; clks(4);
    sda_m = 1'b1;
  endtask

  typedef enum logic [1:0] {OP_START, OP_STOP, OP_WR, OP_RD} op_e;

  // WR: data = byte, exp_bit = expected ACK level, stb/stb_addr = expected strobe.
  // RD: data[0] = master ACK level, exp_byte = expected byte.  START/STOP: exp_bit = busy.
  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic       exp_bit;
    logic [7:0] exp_byte;
    logic       stb;
    logic [7:0] stb_addr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(op_e op, logic [7:0] d, logic eb, logic [7:0] ebyte,
                              logic s, logic [7:0] sa);
    vec_t v;
    v.op = op; v.data = d; v.exp_bit = eb; v.exp_byte = ebyte; v.stb = s; v.stb_addr = sa;
    tbl.push_back(v);
  endfunction

  function automatic void add_start();                 add(OP_START, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00); endfunction
  function automatic void add_stop();                  add(OP_STOP,  8'h00, 1'b0, 8'h00, 1'b0, 8'h00); endfunction
  function automatic void add_wr(logic [7:0] d, logic ack, logic s, logic [7:0] sa);
    add(OP_WR, d, ack, 8'h00, s, sa);
  endfunction
  function automatic void add_rd(logic ack, logic [7:0] exp);
    add(OP_RD, {7'd0, ack}, 1'b0, exp, 1'b0, 8'h00);
  endfunction

  task automatic apply(input int idx, input vec_t v);
    logic       a;
    logic [7:0] b;
    int         c0;
    case (v.op)
      OP_START: begin
        i2c_start();
        check($sformatf("v%0d_busy_after_start", idx), 32'(busy), 32'(v.exp_bit));
      end
      OP_STOP: begin
        i2c_stop();
        clks(2);
        check($sformatf("v%0d_busy_after_stop", idx), 32'(busy), 32'(v.exp_bit));
      end
      OP_WR: begin
        c0 = stb_cnt;
        write_byte(v.data, a);
        check($sformatf("v%0d_ack", idx), 32'(a), 32'(v.exp_bit));
        check($sformatf("v%0d_strobe_count", idx), 32'(stb_cnt - c0), 32'(v.stb));
        if (v.stb) begin
          check($sformatf("v%0d_wr_addr", idx), 32'(stb_addr), 32'(v.stb_addr));
          check($sformatf("v%0d_wr_data", idx), 32'(stb_data), 32'(v.data));
        end
      end
      default: begin
        read_byte(v.data[0], b);
        check($sformatf("v%0d_read_byte", idx), 32'(b), 32'(v.exp_byte));
      end
    endcase
  endtask

  task automatic run_from(input int lo);
    for (int i = lo; i < tbl.size(); i++) apply(i, tbl[i]);
  endtask

  initial begin
    int         lo;
    int         c0;
    logic [7:0] addr_byte;

    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    clks(5);
    reset = 1'b0;
    @(negedge clk);
    check("reset_sda_oe",    32'(sda_oe),    32'd0);
    check("reset_wr_strobe", 32'(wr_strobe), 32'd0);
    check("reset_wr_addr",   32'(wr_addr),   32'd0);
    check("reset_wr_data",   32'(wr_data),   32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    clks(4);

    // Single write of 0xA5 to register 3.
    add_start(); add_wr(8'hA0, I2C_ACK, 1'b0, 8'h00); add_wr(8'h03, I2C_ACK, 1'b0, 8'h00);
    add_wr(8'hA5, I2C_ACK, 1'b1, 8'h03); add_stop();
    // Pointer write, repeated START, one-byte read ended by NACK.
    add_start(); add_wr(8'hA0, I2C_ACK, 1'b0, 8'h00); add_wr(8'h03, I2C_ACK, 1'b0, 8'h00);
    add_start(); add_wr(8'hA1, I2C_ACK, 1'b0, 8'h00); add_rd(I2C_NACK, 8'hA5); add_stop();
    // Foreign address: NACK, no strobe.
    add_start(); add_wr(8'hA2, I2C_NACK, 1'b0, 8'h00); add_stop();
    // Burst write crossing the end of the register file.
    add_start(); add_wr(8'hA0, I2C_ACK, 1'b0, 8'h00); add_wr(8'h0E, I2C_ACK, 1'b0, 8'h00);
    add_wr(8'h11, I2C_ACK, 1'b1, 8'h0E); add_wr(8'h22, I2C_ACK, 1'b1, 8'h0F);
    add_wr(8'h33, I2C_ACK, 1'b0, 8'h00); add_stop();
    // Burst read back across the end of the register file.
    add_start(); add_wr(8'hA0, I2C_ACK, 1'b0, 8'h00); add_wr(8'h0E, I2C_ACK, 1'b0, 8'h00);
    add_start(); add_wr(8'hA1, I2C_ACK, 1'b0, 8'h00);
    add_rd(I2C_ACK, 8'h11); add_rd(I2C_ACK, 8'h22); add_rd(I2C_NACK, 8'hFF); add_stop();
    // Read starting out of range.
    add_start(); add_wr(8'hA0, I2C_ACK, 1'b0, 8'h00); add_wr(8'h10, I2C_ACK, 1'b0, 8'h00);
    add_start(); add_wr(8'hA1, I2C_ACK, 1'b0, 8'h00);
    add_rd(I2C_ACK, 8'hFF); add_rd(I2C_NACK, 8'hFF); add_stop();
    run_from(0);

    // STOP after 4 data bits: byte discarded.
    lo = tbl.size();
    add_start(); add_wr(8'hA0, I2C_ACK, 1'b0, 8'h00); add_wr(8'h04, I2C_ACK, 1'b0, 8'h00);
    run_from(lo);
    c0 = stb_cnt;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    clks(2);
    check("partial_no_strobe", 32'(stb_cnt - c0), 32'd0);
    check("partial_busy",      32'(busy),         32'd0);
    check("partial_state",     32'(dut.state),    32'(IDLE));
    check("partial_sda_oe",    32'(sda_oe),       32'd0);
    lo = tbl.size();
    add_start(); add_wr(8'hA0, I2C_ACK, 1'b0, 8'h00); add_wr(8'h04, I2C_ACK, 1'b0, 8'h00);
    add_start(); add_wr(8'hA1, I2C_ACK, 1'b0, 8'h00); add_rd(I2C_NACK, 8'h00); add_stop();
    run_from(lo);

    // Reset while the target is driving the address ACK.
    i2c_start();
    addr_byte = 8'hA0;
    for (int i = 7; i >= 0; i--) send_bit(addr_byte[i]);
    sda_m = 1'b1; clks(4);
    scl_m = 1'b1;
    for (int k = 0; k < 20 && !sda_oe; k++) clks(1);
    check("ack_driven_before_reset", 32'(sda_oe), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_ack_sda_oe",    32'(sda_oe),    32'd0);
    check("rst_ack_busy",      32'(busy),      32'd0);
    check("rst_ack_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_ack_wr_addr",   32'(wr_addr),   32'd0);
    check("rst_ack_wr_data",   32'(wr_data),   32'd0);
    clks(3);
    reset = 1'b0;
    clks(4);
    scl_m = 1'b0; clks(4);
    send_bit(1'b0); send_bit(1'b1);
    check("post_reset_ignores_bus", 32'(busy), 32'd0);
    check("post_reset_sda_oe",      32'(sda_oe), 32'd0);
    i2c_stop();
    clks(4);
    lo = tbl.size();
    add_start(); add_wr(8'hA0, I2C_ACK, 1'b0, 8'h00); add_wr(8'h03, I2C_ACK, 1'b0, 8'h00);
    add_start(); add_wr(8'hA1, I2C_ACK, 1'b0, 8'h00); add_rd(I2C_NACK, 8'h00); add_stop();
    run_from(lo);

    check("strobe_single_cycle", 32'(stb_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
